// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALUOp / alu_control codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Selects not driven by a state default to the 00 encoding.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic sign);
    case (f3)
      3'b000:  return zero;
      3'b001:  return ~zero;
      3'b100:  return sign;
      3'b101:  return ~sign;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        // Only R-type uses funct7b5; for I-type that bit belongs to the immediate.
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with memory handshake stalls and a retire counter.
// Optional ILLEGAL_TRAP_EN: illegal instructions halt the FSM and raise illegal_instr.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_W  = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic                    zero_flag,
  input  logic                    sign_flag,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    adr_src,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic                    reg_write,
  output logic [2:0]              alu_control,
  output logic                    instr_retired,
  output logic [RETIRE_CNT_W-1:0] retire_count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                    illegal_instr
`endif
);

  localparam logic HS_BYPASS = (MEM_HANDSHAKE == 0);

  state_t                  state_q, state_d;
  logic                    armed_q;
  logic [RETIRE_CNT_W-1:0] retire_count_q;

  logic ready;
  logic is_lw, is_sw, is_r, is_i, is_br, is_jal, illegal;
  logic [1:0] alu_op;
  logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, retire_raw;

  assign ready  = mem_ready | HS_BYPASS;
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_br  = (opcode == OP_BR);
  assign is_jal = (opcode == OP_JAL);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = ~(is_lw | is_sw | is_r | is_i | is_br | is_jal) |
                   (is_br & ~branch_f3_legal(funct3));
`else
  assign illegal = ~(is_lw | is_sw | is_r | is_i | is_br | is_jal);
`endif

  // armed_q stays low through reset and the first cycle after release, so no
  // write enable or FETCH advance can happen until the datapath has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FETCH;
      armed_q        <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (instr_retired) retire_count_q <= retire_count_q + RETIRE_CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        ir_write_raw = ready;
        pc_write_raw = ready;
        if (ready && armed_q) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          retire_raw = 1'b1;
          state_d    = S_FETCH;
`endif
        end else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)               state_d = S_EXECR;
        else if (is_i)               state_d = S_EXECI;
        else if (is_br)              state_d = S_BRANCH;
        else                         state_d = S_JAL;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (is_lw)      state_d = S_MEMREAD;
        else if (is_sw) state_d = S_MEMWRITE;
        else            state_d = S_FETCH;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (ready) begin
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_SUB;
        pc_write_raw = branch_taken(funct3, zero_flag, sign_flag);
        retire_raw   = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // Loads PC with the target from ALUOut while PC+4 goes to ALUWB for rd.
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i     (alu_op),
    .op5_i        (opcode[5]),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .alu_control_o(alu_control)
  );

  assign pc_write      = pc_write_raw  & armed_q;
  assign mem_write     = mem_write_raw & armed_q;
  assign ir_write      = ir_write_raw  & armed_q;
  assign reg_write     = reg_write_raw & armed_q;
  assign instr_retired = retire_raw    & armed_q;
  assign retire_count  = retire_count_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, multi-cycle corner
// sequences and a randomized run against a phase-list reference model.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7b5, zero_flag, sign_flag, mem_ready;

  logic a_pcw, a_adr, a_mw, a_irw, a_rw, a_ret;
  logic [1:0] a_rs, a_sa, a_sb;
  logic [2:0] a_alu;
  logic [3:0] a_cnt;
  logic b_pcw, b_adr, b_mw, b_irw, b_rw, b_ret;
  logic [1:0] b_rs, b_sa, b_sb;
  logic [2:0] b_alu;
  logic [31:0] b_cnt;
`ifdef ILLEGAL_TRAP_EN
  logic a_ill, b_ill;
`endif

  multicycle_control_unit #(.RETIRE_CNT_W(4), .MEM_HANDSHAKE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .mem_ready(mem_ready),
    .pc_write(a_pcw), .adr_src(a_adr), .mem_write(a_mw), .ir_write(a_irw),
    .result_src(a_rs), .alu_src_a(a_sa), .alu_src_b(a_sb), .reg_write(a_rw),
    .alu_control(a_alu), .instr_retired(a_ret), .retire_count(a_cnt)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(a_ill)
`endif
  );

  multicycle_control_unit #(.RETIRE_CNT_W(32), .MEM_HANDSHAKE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .mem_ready(mem_ready),
    .pc_write(b_pcw), .adr_src(b_adr), .mem_write(b_mw), .ir_write(b_irw),
    .result_src(b_rs), .alu_src_a(b_sa), .alu_src_b(b_sb), .reg_write(b_rw),
    .alu_control(b_alu), .instr_retired(b_ret), .retire_count(b_cnt)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(b_ill)
`endif
  );

  // Output vector: {pcw, adr, mw, irw, rs[1:0], sa[1:0], sb[1:0], rw, alu[2:0], ret}
  logic use_b;
  logic [14:0] a_vec, b_vec, obs_vec;
  logic [31:0] obs_cnt;
  assign a_vec   = {a_pcw, a_adr, a_mw, a_irw, a_rs, a_sa, a_sb, a_rw, a_alu, a_ret};
  assign b_vec   = {b_pcw, b_adr, b_mw, b_irw, b_rs, b_sa, b_sb, b_rw, b_alu, b_ret};
  assign obs_vec = use_b ? b_vec : a_vec;
  assign obs_cnt = use_b ? b_cnt : {28'd0, a_cnt};

  int n_chk = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(logic pcw, logic adr, logic mw, logic irw,
                                     logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic rw, logic [2:0] alu, logic ret);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, alu, ret};
  endfunction

  localparam logic [14:0] FETCH_IDLE = 15'b000_0_10_00_10_0_000_0;
  localparam logic [14:0] EN_MASK    = 15'h5811;

  function automatic logic [2:0] alu_f(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic take(logic [2:0] f3, logic z, logic s);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return s;
    if (f3 == 3'b101) return !s;
    return 1'b0;
  endfunction

  function automatic bit legal_op(logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    #1;
    chk("reset_outputs", obs_vec, FETCH_IDLE);
    chk("reset_count", obs_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_release_idle", obs_vec, FETCH_IDLE);
  endtask

  // One instruction from FETCH; mem_ready bit c of rp is applied in cycle c.
  task automatic run_one(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input logic [15:0] rp,
                         output int cyc, output int rw, output int mw, output logic pcw_last,
                         output logic [2:0] alu2, output logic [1:0] rs_rw,
                         output logic [31:0] cnt0);
    cyc = 0; rw = 0; mw = 0; pcw_last = 1'b0; alu2 = 3'b000; rs_rw = 2'b11; cnt0 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      opcode = op; funct3 = f3; funct7b5 = f7; zero_flag = z; sign_flag = s;
      mem_ready = (c < 16) ? rp[c] : 1'b1;
      #1;
      if (c == 0) cnt0 = obs_cnt;
      if (c == 2) alu2 = obs_vec[3:1];
      if (obs_vec[4]) begin rw++; rs_rw = obs_vec[10:9]; end
      if (obs_vec[12]) mw++;
      if (obs_vec[0]) begin
        cyc = c + 1;
        pcw_last = obs_vec[14];
        break;
      end
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z; logic s; logic ill;
    int cyc; int rw; int mw; logic pcw; logic [2:0] alu2;
  } vec_t;
  vec_t tbl[18];

  typedef struct { int kind; logic [14:0] out; } ph_t;
  ph_t q[$];

  task automatic push(input int kind, input logic [14:0] out);
    ph_t p;
    p.kind = kind; p.out = out;
    q.push_back(p);
  endtask

  // Expected phase list of one instruction. Kinds: 0 fixed, 1 fetch wait,
  // 2 read wait, 3 write wait (retires when ready), 4 branch (flags now).
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bit ill;
    ill = !legal_op(op);
    push(1, FETCH_IDLE);
    push(0, pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, ill));
    if (op == OP_LW) begin
      push(0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      push(2, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      push(0, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 1));
    end else if (op == OP_SW) begin
      push(0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      push(3, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
    end else if (op == OP_R || op == OP_I) begin
      push(0, pk(0, 0, 0, 0, 2'b00, 2'b10, (op == OP_I) ? 2'b01 : 2'b00, 0, alu_f(op, f3, f7), 0));
      push(0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1));
    end else if (op == OP_BR) begin
      push(4, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 1));
    end else if (op == OP_JAL) begin
      push(0, pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 0));
      push(0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1));
    end
  endtask

  initial begin
    int cyc, rw, mw, exp_cnt, mcnt, guard;
    logic pcw_last;
    logic [2:0] alu2;
    logic [1:0] rs_rw;
    logic [31:0] cnt0;
    logic [6:0] rop;
    logic [2:0] rf3;
    logic rf7;
    logic [14:0] e;
    ph_t ph;
    logic [6:0] ill_ops[5];
    logic [6:0] ops[6];

    ill_ops = '{7'h7F, 7'h00, 7'b0010111, 7'b0110111, 7'b1100111};
    ops     = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
    //          op      f3      f7 z  s  ill cyc rw mw pcw alu2
    tbl[0]  = '{OP_LW,  3'b010, 0, 0, 0, 0, 5, 1, 0, 0, 3'b000};
    tbl[1]  = '{OP_SW,  3'b010, 0, 0, 0, 0, 4, 0, 1, 0, 3'b000};
    tbl[2]  = '{OP_R,   3'b000, 1, 0, 0, 0, 4, 1, 0, 0, 3'b001};
    tbl[3]  = '{OP_R,   3'b000, 0, 0, 0, 0, 4, 1, 0, 0, 3'b000};
    tbl[4]  = '{OP_R,   3'b111, 0, 0, 0, 0, 4, 1, 0, 0, 3'b010};
    tbl[5]  = '{OP_R,   3'b010, 0, 0, 0, 0, 4, 1, 0, 0, 3'b101};
    tbl[6]  = '{OP_R,   3'b110, 0, 0, 0, 0, 4, 1, 0, 0, 3'b011};
    tbl[7]  = '{OP_I,   3'b000, 1, 0, 0, 0, 4, 1, 0, 0, 3'b000};
    tbl[8]  = '{OP_I,   3'b001, 0, 0, 0, 0, 4, 1, 0, 0, 3'b000};
    tbl[9]  = '{OP_BR,  3'b000, 0, 1, 0, 0, 3, 0, 0, 1, 3'b001};
    tbl[10] = '{OP_BR,  3'b001, 0, 1, 0, 0, 3, 0, 0, 0, 3'b001};
    tbl[11] = '{OP_BR,  3'b100, 0, 0, 1, 0, 3, 0, 0, 1, 3'b001};
    tbl[12] = '{OP_BR,  3'b101, 0, 0, 1, 0, 3, 0, 0, 0, 3'b001};
    tbl[13] = '{OP_BR,  3'b000, 0, 0, 0, 0, 3, 0, 0, 0, 3'b001};
    tbl[14] = '{OP_BR,  3'b101, 0, 0, 0, 0, 3, 0, 0, 1, 3'b001};
    tbl[15] = '{OP_BR,  3'b010, 0, 1, 1, 1, 3, 0, 0, 0, 3'b001};
    tbl[16] = '{OP_JAL, 3'b000, 0, 0, 0, 0, 4, 1, 0, 0, 3'b000};
    tbl[17] = '{7'h7F,  3'b000, 0, 0, 0, 1, 2, 0, 0, 0, 3'b000};

    use_b = 1'b0; rst_n = 1'b1; opcode = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    zero_flag = 1'b0; sign_flag = 1'b0; mem_ready = 1'b1;
    do_reset();

    // lw with one wait cycle in FETCH and one in MEMREAD
    run_one(OP_LW, 3'b010, 0, 0, 0, 16'hFFEE, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
    chk("lw_wait_cycles", cyc, 7);
    chk("lw_wait_regwrite", rw, 1);
    chk("lw_wait_result_src", rs_rw, 2'b01);
    chk("lw_wait_count_before", cnt0, 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("lw_wait_count_after", obs_cnt, 1);

    exp_cnt = 1;
    for (int i = 0; i < 18; i++) begin
      if (TRAP && tbl[i].ill) continue;
      run_one(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].s, 16'hFFFF,
              cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
      chk($sformatf("vec%0d_count", i), cnt0, exp_cnt % 16);
      chk($sformatf("vec%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("vec%0d_regwrite", i), rw, tbl[i].rw);
      chk($sformatf("vec%0d_memwrite", i), mw, tbl[i].mw);
      chk($sformatf("vec%0d_pcwrite", i), pcw_last, tbl[i].pcw);
      if (tbl[i].cyc > 2) chk($sformatf("vec%0d_alu", i), alu2, tbl[i].alu2);
      exp_cnt++;
    end

    // Reset asserted while a store is stalled in its write phase
    @(negedge clk); opcode = OP_SW; funct3 = 3'b010; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    chk("sw_stall_memwrite", obs_vec[12], 1);
    @(negedge clk); #1;
    chk("sw_stall_memwrite2", obs_vec[12], 1);
    chk("sw_stall_no_retire", obs_vec[0], 0);
    rst_n = 1'b0; #1;
    chk("abort_outputs", obs_vec, FETCH_IDLE);
    chk("abort_enables", obs_vec & EN_MASK, 0);
    chk("abort_count", obs_cnt, 0);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("abort_release_idle", obs_vec, FETCH_IDLE);
    chk("abort_release_count", obs_cnt, 0);

    // 16 retirements wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      run_one(OP_I, 3'b000, 0, 0, 0, 16'hFFFF, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
      chk($sformatf("wrap%0d_count", i), cnt0, i);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("wrap_to_zero", obs_cnt, 0);

    // Randomized instruction stream with random stalls and flags
    mcnt = 0;
    for (int n = 0; n < 250; n++) begin
      if (TRAP || $urandom_range(0, 6) != 6) rop = ops[$urandom_range(0, 5)];
      else rop = ill_ops[$urandom_range(0, 4)];
      rf3 = 3'($urandom);
      rf7 = 1'($urandom);
      if (TRAP && rop == OP_BR) rf3 = {rf3[2], 1'b0, rf3[0]};
      build(rop, rf3, rf7);
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        @(negedge clk);
        opcode = rop; funct3 = rf3; funct7b5 = rf7;
        zero_flag = 1'($urandom); sign_flag = 1'($urandom);
        mem_ready = ($urandom_range(0, 3) != 0);
        #1;
        ph = q[0];
        e = ph.out;
        if (ph.kind == 1) begin e[14] = mem_ready; e[11] = mem_ready; end
        if (ph.kind == 3) e[0] = mem_ready;
        if (ph.kind == 4) e[14] = take(rf3, zero_flag, sign_flag);
        chk("rand_outputs", obs_vec, e);
        chk("rand_count", obs_cnt, mcnt % 16);
        if (e[0]) mcnt++;
        if (ph.kind == 0 || ph.kind == 4 || mem_ready) void'(q.pop_front());
        guard++;
      end
      if (guard >= 200) begin
        chk("rand_bound", guard, 0);
        q.delete();
      end
    end

    // Handshake disabled: mem_ready low never stalls
    use_b = 1'b1;
    do_reset();
    run_one(OP_SW, 3'b010, 0, 0, 0, 16'h0000, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
    chk("nohs_sw_cycles", cyc, 4);
    chk("nohs_sw_memwrite", mw, 1);
    chk("nohs_sw_count", cnt0, 0);
    run_one(OP_LW, 3'b010, 0, 0, 0, 16'h0000, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
    chk("nohs_lw_cycles", cyc, 5);
    chk("nohs_lw_regwrite", rw, 1);
    chk("nohs_lw_count", cnt0, 1);
    use_b = 1'b0;

`ifdef ILLEGAL_TRAP_EN
    do_reset();
    chk("trap_ill_reset", a_ill, 0);
    run_one(7'h7F, 3'b000, 0, 0, 0, 16'hFFFF, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
    chk("trap_no_retire", cyc, 0);
    chk("trap_ill_set", a_ill, 1);
    chk("trap_enables", obs_vec & EN_MASK, 0);
    chk("trap_count", obs_cnt, 0);
    do_reset();
    chk("trap_ill_cleared", a_ill, 0);
    run_one(OP_BR, 3'b011, 0, 1, 1, 16'hFFFF, cyc, rw, mw, pcw_last, alu2, rs_rw, cnt0);
    chk("trap_br_no_retire", cyc, 0);
    chk("trap_br_ill_set", a_ill, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
